// File: rtl/data_memory_lsu_if.sv
// Request/response bundle between a core load-store stage and data_memory_lsu.
// The master drives requests; the slave (the memory) returns fixed-latency responses.
interface data_memory_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_lsu.sv
// Word-organised data RAM with byte/half/word load-store, extension, error checking,
// a hardware clear sequence after reset and a 1- or 2-cycle response pipeline.
module data_memory_lsu #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_DEPTH    = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    output logic               busy,
    data_memory_lsu_if.slave   bus
);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int N_LANES = DATA_WIDTH / 8;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   clr_idx_q;
    logic               busy_q;
    logic               ready_q;

    // Clear FSM: one zero word per cycle, then idle forever until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_idx_q <= clr_idx_q + IDX_W'(1);
                    if (clr_idx_q == IDX_W'(MEM_DEPTH - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign bus.req_ready = ready_q;

    logic             accept;
    logic [IDX_W-1:0] req_idx;
    logic [1:0]       req_lane;
    logic             range_err;
    logic             size_err;
    logic             req_err;

    assign accept    = bus.req_valid & ready_q & ~rst;
    assign req_idx   = bus.req_addr[IDX_W+1:2];
    assign req_lane  = bus.req_addr[1:0];
    assign range_err = (bus.req_addr >> (IDX_W + 2)) != '0;
    assign req_err   = range_err | size_err;

    always_comb begin
        size_err = 1'b0;
        case (bus.req_size)
            2'b00:   size_err = 1'b0;
            2'b01:   size_err = req_lane[0];
            2'b10:   size_err = (req_lane != 2'b00);
            default: size_err = 1'b1;
        endcase
    end

    logic [N_LANES-1:0]    wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

    // Narrow stores replicate their data across lanes; byte enables pick the target lanes.
    always_comb begin
        wr_en   = '0;
        wr_idx  = req_idx;
        wr_data = bus.req_wdata;
        if (state_q == S_CLEAR) begin
            wr_en   = '1;
            wr_idx  = clr_idx_q;
            wr_data = '0;
        end else if (accept && bus.req_we && !req_err) begin
            case (bus.req_size)
                2'b00: begin
                    wr_en   = N_LANES'(1) << req_lane;
                    wr_data = {N_LANES{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                    wr_en   = req_lane[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                    wr_en   = '1;
                    wr_data = bus.req_wdata;
                end
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DEPTH];
            logic [7:0] rd_byte_q;

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
                end
                rd_byte_q <= lane_mem[req_idx];
            end

            assign rd_word[gi*8 +: 8] = rd_byte_q;
        end
    endgenerate

    logic       v1_q;
    logic       err1_q;
    logic       ld1_q;
    logic [1:0] size1_q;
    logic [1:0] lane1_q;
    logic       uns1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            err1_q  <= 1'b0;
            ld1_q   <= 1'b0;
            size1_q <= 2'b00;
            lane1_q <= 2'b00;
            uns1_q  <= 1'b0;
        end else begin
            v1_q    <= accept;
            err1_q  <= accept & req_err;
            ld1_q   <= accept & ~bus.req_we & ~req_err;
            size1_q <= bus.req_size;
            lane1_q <= req_lane;
            uns1_q  <= bus.req_unsigned;
        end
    end

    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] ext_data;
    logic [DATA_WIDTH-1:0] ld_data;

    assign sel_byte = rd_word[{lane1_q, 3'b000} +: 8];
    assign sel_half = lane1_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ext_data = rd_word;
        case (size1_q)
            2'b00:   ext_data = {{(DATA_WIDTH-8){sel_byte[7] & ~uns1_q}}, sel_byte};
            2'b01:   ext_data = {{(DATA_WIDTH-16){sel_half[15] & ~uns1_q}}, sel_half};
            default: ext_data = rd_word;
        endcase
    end

    // Stores and errors return zero; idle cycles are zero because ld1_q is clear.
    assign ld_data = ld1_q ? ext_data : '0;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  v2_q;
            logic                  err2_q;
            logic [DATA_WIDTH-1:0] rdata2_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v2_q     <= 1'b0;
                    err2_q   <= 1'b0;
                    rdata2_q <= '0;
                end else begin
                    v2_q     <= v1_q;
                    err2_q   <= err1_q;
                    rdata2_q <= ld_data;
                end
            end

            assign bus.rsp_valid = v2_q;
            assign bus.rsp_err   = err2_q;
            assign bus.rsp_rdata = rdata2_q;
        end else begin : g_lat1
            assign bus.rsp_valid = v1_q;
            assign bus.rsp_err   = err1_q;
            assign bus.rsp_rdata = ld_data;
        end
    endgenerate
endmodule
